// File: rtl/randomizer_pkg.sv
// Shared constants and types for the LFSR randomizer and its sequencing controller.
package randomizer_pkg;

    localparam int unsigned LfsrWidth = 16;

    // Fibonacci feedback taps (bit indices)
    localparam int unsigned TapA = 15;
    localparam int unsigned TapB = 10;
    localparam int unsigned TapC = 9;
    localparam int unsigned TapD = 5;

    localparam logic [LfsrWidth-1:0] DefaultSeed = 16'hACE1;

    typedef enum logic [1:0] {
        StSeed,
        StWait,
        StReady
    } state_e;

    // One shift of the randomizer: feedback enters at the MSB, state moves toward bit 0
    function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] v);
        return {v[TapA] ^ v[TapB] ^ v[TapC] ^ v[TapD], v[LfsrWidth-1:1]};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt_oh,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int unsigned IW = $clog2(NREQ);

    logic              found;
    int unsigned       sum;
    logic [IW-1:0]     idx;

    // Scan requesters in rotated order starting from ptr, take the first hit
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sum = 32'(ptr) + i;
            idx = IW'(sum % NREQ);
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/randomizer_ctrl.sv
// Seeds the LFSR randomizer, enforces a shift gap between issued values, recovers from
// the all-zero lockup state and shares the generator among NREQ round-robin requesters.
module randomizer_ctrl
    import randomizer_pkg::*;
#(
    parameter int unsigned          NREQ = 4,
    parameter int unsigned          STEP = 16,
    parameter logic [LfsrWidth-1:0] SEED = DefaultSeed
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    seed_valid,
    input  logic [LfsrWidth-1:0]    seed,
    output logic                    seed_ready,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic                    rnd_valid,
    output logic [LfsrWidth-1:0]    rnd_data,
    output logic [$clog2(NREQ)-1:0] rnd_id,
    output logic                    lockup,
    output logic [LfsrWidth-1:0]    lfsr_ic,
    output logic                    lfsr_start,
    input  logic [LfsrWidth-1:0]    lfsr_q
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = (STEP > 1) ? $clog2(STEP) : 1;

    state_e                 state_q;
    logic [LfsrWidth-1:0]   seed_reg_q;
    logic [IW-1:0]          rr_ptr_q;
    logic [CW-1:0]          step_cnt_q;
    logic [NREQ-1:0]        gnt_q;
    logic                   rnd_valid_q;
    logic [LfsrWidth-1:0]   rnd_data_q;
    logic [IW-1:0]          rnd_id_q;
    logic                   lockup_q;

    logic                   seed_accept;
    logic                   zero_state;
    logic [NREQ-1:0]        arb_oh;
    logic [IW-1:0]          arb_idx;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx)
    );

    // Decoded controls; reset forces a seed load so the randomizer starts from SEED
    always_comb begin
        seed_ready  = ~rst & (state_q != StSeed);
        lfsr_start  = rst | (state_q == StSeed);
        lfsr_ic     = rst ? SEED : seed_reg_q;
        seed_accept = seed_valid & seed_ready;
        // SEED is excluded: the LFSR output is stale until the load lands
        zero_state  = (state_q != StSeed) && (lfsr_q == '0);
    end

    // Sequencer FSM with registered grant and lockup outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StSeed;
            seed_reg_q  <= SEED;
            rr_ptr_q    <= '0;
            step_cnt_q  <= '0;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= '0;
            rnd_id_q    <= '0;
            lockup_q    <= 1'b0;
        end else begin
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            lockup_q    <= 1'b0;
            if (seed_accept) begin
                seed_reg_q <= (seed == '0) ? SEED : seed;
                state_q    <= StSeed;
            end else if (zero_state) begin
                // Never reuse the user seed here, it may be the one that locked up
                seed_reg_q <= SEED;
                state_q    <= StSeed;
                lockup_q   <= 1'b1;
            end else begin
                unique case (state_q)
                    StSeed: begin
                        step_cnt_q <= '0;
                        state_q    <= StWait;
                    end
                    StWait: begin
                        step_cnt_q <= step_cnt_q + 1'b1;
                        if (step_cnt_q == CW'(STEP - 1)) begin
                            state_q <= StReady;
                        end
                    end
                    StReady: begin
                        if (|req) begin
                            gnt_q       <= arb_oh;
                            rnd_valid_q <= 1'b1;
                            rnd_data_q  <= lfsr_q;
                            rnd_id_q    <= arb_idx;
                            rr_ptr_q    <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                            step_cnt_q  <= '0;
                            state_q     <= StWait;
                        end
                    end
                    default: state_q <= StSeed;
                endcase
            end
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd_data  = rnd_data_q;
    assign rnd_id    = rnd_id_q;
    assign lockup    = lockup_q;

endmodule

// File: tb/tb_randomizer_ctrl.sv
// Scoreboard bench for randomizer_ctrl: two instances (STEP=16 and STEP=1), each driving
// a behavioural 16-bit Fibonacci LFSR (taps 15,10,9,5, shift toward bit 0).
module tb_randomizer_ctrl;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // STEP=16 instance
    logic        seed_valid16 = 1'b0;
    logic [15:0] seed16 = '0;
    logic        seed_ready16;
    logic [3:0]  req16 = '0;
    logic [3:0]  gnt16;
    logic        rnd_valid16;
    logic [15:0] rnd_data16;
    logic [1:0]  rnd_id16;
    logic        lockup16;
    logic [15:0] lfsr_ic16;
    logic        lfsr_start16;
    logic [15:0] lfsr_q16 = '0;

    // STEP=1 instance
    logic        seed_valid1 = 1'b0;
    logic [15:0] seed1 = '0;
    logic        seed_ready1;
    logic [3:0]  req1 = '0;
    logic [3:0]  gnt1;
    logic        rnd_valid1;
    logic [15:0] rnd_data1;
    logic [1:0]  rnd_id1;
    logic        lockup1;
    logic [15:0] lfsr_ic1;
    logic        lfsr_start1;
    logic [15:0] lfsr_q1 = '0;

    exp_t sb16[$];
    exp_t sb1[$];
    int   gcyc16[$];
    int   gcnt16 = 0;
    int   gcnt1 = 0;
    exp_t e16;
    exp_t e1;
    logic [3:0] oh16;
    logic [3:0] oh1;

    randomizer_ctrl #(
        .NREQ (4),
        .STEP (16),
        .SEED (16'hACE1)
    ) dut16 (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid16),
        .seed       (seed16),
        .seed_ready (seed_ready16),
        .req        (req16),
        .gnt        (gnt16),
        .rnd_valid  (rnd_valid16),
        .rnd_data   (rnd_data16),
        .rnd_id     (rnd_id16),
        .lockup     (lockup16),
        .lfsr_ic    (lfsr_ic16),
        .lfsr_start (lfsr_start16),
        .lfsr_q     (lfsr_q16)
    );

    randomizer_ctrl #(
        .NREQ (4),
        .STEP (1),
        .SEED (16'hACE1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid1),
        .seed       (seed1),
        .seed_ready (seed_ready1),
        .req        (req1),
        .gnt        (gnt1),
        .rnd_valid  (rnd_valid1),
        .rnd_data   (rnd_data1),
        .rnd_id     (rnd_id1),
        .lockup     (lockup1),
        .lfsr_ic    (lfsr_ic1),
        .lfsr_start (lfsr_start1),
        .lfsr_q     (lfsr_q1)
    );

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
        logic [15:0] x;
        x = v;
        for (int i = 0; i < n; i++) begin
            x = {x[15] ^ x[10] ^ x[9] ^ x[5], x[15:1]};
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Randomizer models: load on start, otherwise shift every clock
    always @(posedge clk) lfsr_q16 <= lfsr_start16 ? lfsr_ic16 : lfsr_adv(lfsr_q16, 1);
    always @(posedge clk) lfsr_q1  <= lfsr_start1  ? lfsr_ic1  : lfsr_adv(lfsr_q1, 1);

    // Monitor for the STEP=16 instance
    always @(negedge clk) begin
        if (rnd_valid16 === 1'b1) begin
            gcnt16++;
            gcyc16.push_back(cyc);
            check("sb16_pending", 32'(sb16.size() != 0), 32'(1));
            if (sb16.size() != 0) begin
                e16 = sb16.pop_front();
                check("rnd_id16", 32'(rnd_id16), 32'(e16.id));
                check("rnd_data16", 32'(rnd_data16), 32'(e16.data));
            end
            oh16 = 4'b0001 << rnd_id16;
            check("gnt16_onehot", 32'(gnt16), 32'(oh16));
            check("rnd_data16_nonzero", 32'(rnd_data16 != '0), 32'(1));
        end
    end

    // Monitor for the STEP=1 instance
    always @(negedge clk) begin
        if (rnd_valid1 === 1'b1) begin
            gcnt1++;
            check("sb1_pending", 32'(sb1.size() != 0), 32'(1));
            if (sb1.size() != 0) begin
                e1 = sb1.pop_front();
                check("rnd_id1", 32'(rnd_id1), 32'(e1.id));
                check("rnd_data1", 32'(rnd_data1), 32'(e1.data));
            end
            oh1 = 4'b0001 << rnd_id1;
            check("gnt1_onehot", 32'(gnt1), 32'(oh1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        int          n;
        int          lk_count;

        repeat (3) tick();

        // Reset values
        check("rst_gnt", 32'(gnt16), 32'(0));
        check("rst_rnd_valid", 32'(rnd_valid16), 32'(0));
        check("rst_rnd_data", 32'(rnd_data16), 32'(0));
        check("rst_rnd_id", 32'(rnd_id16), 32'(0));
        check("rst_lockup", 32'(lockup16), 32'(0));
        check("rst_seed_ready", 32'(seed_ready16), 32'(0));
        check("rst_lfsr_start", 32'(lfsr_start16), 32'(1));
        check("rst_lfsr_ic", 32'(lfsr_ic16), 32'(16'hACE1));

        // Seed load on the STEP=1 instance: 8000 shifted once is C000
        rst         = 1'b0;
        seed_valid1 = 1'b1;
        seed1       = 16'h8000;
        req1        = 4'b0001;
        sb1.push_back('{id: 2'd0, data: 16'hC000});
        n = 0;
        do begin
            tick();
            n++;
        end while (seed_ready1 !== 1'b1 && n < 10);
        check("seed1_ready", 32'(seed_ready1), 32'(1));
        tick();
        seed_valid1 = 1'b0;
        check("seed1_start", 32'(lfsr_start1), 32'(1));
        check("seed1_ic", 32'(lfsr_ic1), 32'(16'h8000));
        n = 0;
        while (gcnt1 < 1 && n < 10) begin
            tick();
            n++;
        end
        check("seed1_grant_count", 32'(gcnt1), 32'(1));
        req1 = '0;

        // Round robin on the STEP=16 instance, starting from a fresh reset
        rst = 1'b1;
        repeat (2) tick();
        rst   = 1'b0;
        req16 = 4'b1111;
        v = lfsr_adv(16'hACE1, 16);
        for (int i = 0; i < 5; i++) begin
            sb16.push_back('{id: 2'(i % 4), data: v});
            v = lfsr_adv(v, 17);
        end
        n = 0;
        while (gcnt16 < 5 && n < 200) begin
            tick();
            n++;
        end
        req16 = '0;
        check("rr_grant_count", 32'(gcnt16), 32'(5));
        for (int i = 1; i < 5 && i < gcyc16.size(); i++) begin
            check("rr_spacing", 32'(gcyc16[i] - gcyc16[i-1]), 32'(17));
        end

        // Lockup: seed 0001 shifts to zero on the second WAIT cycle
        tick();
        check("lk_seed_ready", 32'(seed_ready16), 32'(1));
        seed_valid16 = 1'b1;
        seed16       = 16'h0001;
        tick();
        seed_valid16 = 1'b0;
        check("lk_user_ic", 32'(lfsr_ic16), 32'(16'h0001));
        n = 0;
        while (lockup16 !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("lk_pulse", 32'(lockup16), 32'(1));
        check("lk_recover_ic", 32'(lfsr_ic16), 32'(16'hACE1));
        check("lk_recover_start", 32'(lfsr_start16), 32'(1));
        lk_count = 1;
        req16 = 4'b0001;
        sb16.push_back('{id: 2'd0, data: lfsr_adv(16'hACE1, 16)});
        n = 0;
        while (gcnt16 < 6 && n < 40) begin
            tick();
            n++;
            if (lockup16 === 1'b1) lk_count++;
        end
        req16 = '0;
        check("lk_grant_count", 32'(gcnt16), 32'(6));
        check("lk_pulse_count", 32'(lk_count), 32'(1));

        // Zero seed is replaced by the default seed
        tick();
        seed_valid16 = 1'b1;
        seed16       = 16'h0000;
        tick();
        seed_valid16 = 1'b0;
        check("zs_ic", 32'(lfsr_ic16), 32'(16'hACE1));
        check("zs_start", 32'(lfsr_start16), 32'(1));
        check("zs_seed_ready", 32'(seed_ready16), 32'(0));

        // Collision: seed and req[2] in the same READY cycle, seed wins
        repeat (25) tick();
        req16        = 4'b0100;
        seed_valid16 = 1'b1;
        seed16       = 16'h1234;
        sb16.push_back('{id: 2'd2, data: lfsr_adv(16'h1234, 16)});
        tick();
        seed_valid16 = 1'b0;
        check("col_no_grant", 32'(rnd_valid16), 32'(0));
        check("col_ic", 32'(lfsr_ic16), 32'(16'h1234));
        n = 1;
        while (rnd_valid16 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        req16 = '0;
        check("col_latency", 32'(n), 32'(19));

        // Reset in the cycle a grant would be arbitrated
        repeat (25) tick();
        req16 = 4'b1010;
        rst   = 1'b1;
        #1;
        check("rmg_start", 32'(lfsr_start16), 32'(1));
        check("rmg_seed_ready", 32'(seed_ready16), 32'(0));
        tick();
        check("rmg_gnt", 32'(gnt16), 32'(0));
        check("rmg_rnd_valid", 32'(rnd_valid16), 32'(0));
        check("rmg_rnd_data", 32'(rnd_data16), 32'(0));
        rst = 1'b0;
        sb16.push_back('{id: 2'd1, data: lfsr_adv(16'hACE1, 16)});
        n = 0;
        while (gcnt16 < 8 && n < 40) begin
            tick();
            n++;
        end
        req16 = '0;
        check("rmg_grant_count", 32'(gcnt16), 32'(8));

        repeat (5) tick();
        check("sb16_drained", 32'(sb16.size()), 32'(0));
        check("sb1_drained", 32'(sb1.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/randomizer_ctrl.md
# randomizer_ctrl

Sequencing and sharing controller for the 16-bit Fibonacci LFSR randomizer (taps 15, 10, 9, 5; shifts every clock; no enable). It drives the randomizer's seed load, inserts a decorrelation gap between issued values, and detects and recovers the all-zero lockup state. It also shares the generator among `NREQ` requesters with round-robin fairness, so each issued value goes to exactly one requester. It sits between the randomizer instance and agent-side consumers such as action-selection and exploration logic.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `STEP`, 16: minimum LFSR shifts between issued values, ≥1.
- `SEED`, 16'hACE1: reset and lockup-recovery seed, nonzero.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `seed_valid`  in  1: software seed offered.
- `seed`  in  16: seed value.
- `seed_ready`  out  1: seed accepted this cycle when `seed_valid` is also high.
- `req`  in  NREQ: level request per requester.
- `gnt`  out  NREQ: one-hot grant pulse, one cycle.
- `rnd_valid`  out  1: `rnd_data` valid; coincides with `gnt`.
- `rnd_data`  out  16: issued random value.
- `rnd_id`  out  $clog2(NREQ): index of the granted requester.
- `lockup`  out  1: one-cycle pulse when zero-state recovery starts.
- `lfsr_ic`  out  16: connects to randomizer `ic`.
- `lfsr_start`  out  1: connects to randomizer `start`.
- `lfsr_q`  in  16: connects to randomizer `q`.

## Operation
States are SEED, WAIT and READY.
- **SEED:** `lfsr_start`=1 and `lfsr_ic`=`seed_reg`. The state lasts one cycle, clears `step_cnt`, then goes to WAIT.
- **WAIT:** `step_cnt` increments each cycle. When `step_cnt`==`STEP-1` the next state is READY.
- **READY:** if any `req` is high, grant round-robin starting from `rr_ptr`. Register `lfsr_q` into `rnd_data`, clear `step_cnt`, go to WAIT, and set `rr_ptr` to granted+1 mod `NREQ`. With no request, stay in READY.
- **Seed handshake:**
  - `seed_ready`=1 in WAIT and READY, 0 in SEED and during reset.
  - On acceptance, `seed_reg` takes `seed` and the state goes to SEED.
  - A zero seed is replaced by `SEED`.
- **Lockup:**
  - In WAIT or READY, `lfsr_q`==0 forces SEED.
  - `seed_reg` is overwritten with `SEED`, never the user seed, so a degenerate user seed cannot lock up repeatedly.
  - `lockup` pulses on the next cycle.
- **Priority within one cycle:** seed acceptance, then lockup, then grant. A grant that loses to either is not issued, and its `req` stays pending.
- **Requests:** `req` is level-sensitive. Dropping `req` before its grant is legal, and no value is issued for it.
- **Issue guarantee:** every issued value is the LFSR state after at least `STEP` shifts since the last seed load or issue, so no two grants ever receive the same sample.

## Timing
- **Reset values:**
  - Registered outputs: `gnt`=0, `rnd_valid`=0, `rnd_data`=0, `rnd_id`=0, `lockup`=0.
  - Control state: state=SEED, `seed_reg`=`SEED`, `rr_ptr`=0, `step_cnt`=0.
  - Combinational outputs during reset: `lfsr_start`=1 and `lfsr_ic`=`SEED`, so the randomizer loads while in reset.
- **Output registration:** `gnt`, `rnd_valid`, `rnd_data`, `rnd_id` and `lockup` are registered. `lfsr_start` and `lfsr_ic` are decoded from the state. `seed_ready` is decoded from the state and goes low asynchronously with `rst`.
- **Seed-load latency:** the LFSR holds the seed in the first WAIT cycle, and the first READY cycle sees the seed shifted `STEP` times.
- **Grant latency:** `gnt`/`rnd_valid` assert on the cycle after the READY cycle that arbitrated.
- **Throughput:** minimum spacing between grants is `STEP`+1 cycles.
- **Reset mid-operation:** any pending grant is dropped, and the next cycle after release is SEED.

## Structure
- `randomizer_pkg` holds:
  - the state enum (SEED, WAIT, READY);
  - the LFSR width constant (16);
  - the tap-index constants (15, 10, 9, 5);
  - the default seed 16'hACE1.
- Sub-module `rr_arbiter` (parameter `NREQ`; inputs `req`, `ptr`; outputs one-hot `gnt_oh`, binary `gnt_idx`). It is combinational; the pointer register stays in `randomizer_ctrl`.
- The randomizer is instantiated beside `randomizer_ctrl` at the level above, not inside it.

## Test plan
- **Seed load:** `STEP`=1; after reset, offer `seed`=16'h8000 with `req`[0] held high → `seed_ready`=1, SEED, then WAIT. Grant to requester 0 with `rnd_data`=16'hC000 and `rnd_id`=0.
- **Round-robin:** `req`=4'b1111 held high, `STEP`=16 → grants in order 0,1,2,3,0, each 17 cycles apart. All `rnd_data` values are distinct and nonzero.
- **Lockup recovery:** accept `seed`=16'h0001 → `lfsr_q`=0 in the second WAIT cycle, then SEED with `lfsr_ic`=16'hACE1. `lockup` pulses once and no grant carries 0.
- **Priority collision:** assert `seed_valid` in the same READY cycle as `req`[2] → the seed is accepted and no grant is issued. `req`[2] is granted after the reseed plus `STEP` cycles.
- **Zero seed:** offer `seed`=16'h0000 → `lfsr_ic`=16'hACE1 during SEED.
- **Reset mid-grant:** pulse `rst` in the cycle a grant is arbitrated → `gnt`/`rnd_valid` stay 0. `lfsr_start`=1 during reset, and arbitration resumes with `rr_ptr`=0.
